// File: rtl/jk_ff_bank_pkg.sv
// Shared definitions for the JK flip-flop bank.
// Contents:
//   MODE_*      - runtime mode select encodings for the bank
//   jk_cmd_e    - per-cell {j,k} command encodings
//   jk_next()   - next-state function of a single JK cell
package jk_pkg;

  localparam logic [1:0] MODE_JK  = 2'b00;
  localparam logic [1:0] MODE_D   = 2'b01;
  localparam logic [1:0] MODE_T   = 2'b10;
  localparam logic [1:0] MODE_CNT = 2'b11;

  // {j,k} as seen by one cell
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  // Characteristic equation of a JK flip-flop
  function automatic logic jk_next(input logic [1:0] cmd, input logic q);
    logic nxt;
    case (cmd)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_ff_bank_if.sv
// Control/status bundle of the JK flip-flop bank.
// Signals:
//   en    - clock enable (0 = hold)
//   mode  - 00 JK, 01 D, 10 T, 11 COUNT
//   j, k  - per-bit inputs (j doubles as D / T data)
//   q     - registered state, qb = ~q
//   tc    - terminal count flag
//   chg   - registered per-bit change flags
// Modports: master drives controls and observes state; slave is the bank.
interface jk_ff_bank_if #(
  parameter int WIDTH = 4
) ();

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;
  logic [WIDTH-1:0] chg;

  modport master (
    output en, mode, j, k,
    input  q, qb, tc, chg
  );

  modport slave (
    input  en, mode, j, k,
    output q, qb, tc, chg
  );

endinterface

// File: rtl/jk_ff_bank_cell.sv
// Single JK storage cell with synchronous active-low reset and preset.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active low, loads RST_VAL
//   set    - synchronous preset, active low, loads 1 (rst has priority)
//   en     - clock enable, 0 = hold
//   j, k   - JK inputs
//   q      - registered state
//   q_nxt  - value q takes at the next edge (used by the parent for chg)
module jk_cell
  import jk_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_nxt
);

  // Next-state selection in priority order: reset, preset, enable, JK
  always_comb begin
    q_nxt = q;
    if (!rst) begin
      q_nxt = RST_VAL;
    end else if (!set) begin
      q_nxt = 1'b1;
    end else if (!en) begin
      q_nxt = q;
    end else begin
      q_nxt = jk_next({j, k}, q);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RST_VAL;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK cells with runtime mode select (JK, D, T, binary count).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active low, loads RST_VAL and clears chg
//   set  - synchronous preset, active low, loads all ones
//   bus  - slave side of jk_ff_bank_if (en, mode, j, k / q, qb, tc, chg)
// Every mode is mapped onto per-cell J/K so the cells stay identical.
module jk_ff_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set,
  jk_ff_bank_if.slave  bus
);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] cell_j_s;
  logic [WIDTH-1:0] cell_k_s;
  logic [WIDTH-1:0] carry_s;
  logic [WIDTH-1:0] chg_r;

  // Counter carry chain: bit i toggles when all lower bits are one
  assign carry_s[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign carry_s[i] = carry_s[i-1] & q_s[i-1];
  end

  // Map the selected mode onto per-bit J/K
  always_comb begin
    cell_j_s = {WIDTH{1'b0}};
    cell_k_s = {WIDTH{1'b0}};
    case (bus.mode)
      MODE_JK: begin
        cell_j_s = bus.j;
        cell_k_s = bus.k;
      end
      MODE_D: begin
        cell_j_s = bus.j;
        cell_k_s = ~bus.j;
      end
      MODE_T: begin
        cell_j_s = bus.j;
        cell_k_s = bus.j;
      end
      MODE_CNT: begin
        cell_j_s = carry_s;
        cell_k_s = carry_s;
      end
      default: begin
        cell_j_s = {WIDTH{1'b0}};
        cell_k_s = {WIDTH{1'b0}};
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .set   (set),
      .en    (bus.en),
      .j     (cell_j_s[i]),
      .k     (cell_k_s[i]),
      .q     (q_s[i]),
      .q_nxt (q_nxt_s[i])
    );
  end

  // Change flags register alongside q; reset forces them clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      chg_r <= {WIDTH{1'b0}};
    end else begin
      chg_r <= q_nxt_s ^ q_s;
    end
  end

  assign bus.q   = q_s;
  assign bus.qb  = ~q_s;
  assign bus.chg = chg_r;
  assign bus.tc  = (bus.mode == MODE_CNT) && bus.en && (&q_s);

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed self-checking bench for jk_ff_bank (WIDTH=4 main instance plus a
// WIDTH=1 instance with RST_VAL=1 sharing the same controls).
module tb_jk_ff_bank;
  import jk_pkg::*;

  logic clk;
  logic rst;
  logic set;
  int   checks;
  int   errors;
  logic [3:0] cnt;
  logic [3:0] prev;

  jk_ff_bank_if #(.WIDTH(4)) bus ();
  jk_ff_bank_if #(.WIDTH(1)) bus1 ();

  assign bus1.en   = bus.en;
  assign bus1.mode = bus.mode;
  assign bus1.j    = bus.j[0:0];
  assign bus1.k    = bus.k[0:0];

  jk_ff_bank #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .set (set),
    .bus (bus)
  );

  jk_ff_bank #(.WIDTH(1), .RST_VAL(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .set (set),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    set = 1'b0;
    bus.en = 1'b0;
    bus.mode = MODE_JK;
    bus.j = 4'hF;
    bus.k = 4'hF;

    // Reset with preset also asserted: reset wins
    tick();
    tick();
    check("rst_q", {28'd0, bus.q}, 32'h0);
    check("rst_qb", {28'd0, bus.qb}, 32'hF);
    check("rst_chg", {28'd0, bus.chg}, 32'h0);
    check("rst_tc", {31'd0, bus.tc}, 32'h0);
    check("w1_rst_q", {31'd0, bus1.q}, 32'h1);
    check("w1_rst_qb", {31'd0, bus1.qb}, 32'h0);

    // Preset alone
    rst = 1'b1;
    tick();
    check("set_q", {28'd0, bus.q}, 32'hF);
    check("set_chg", {28'd0, bus.chg}, 32'hF);
    check("w1_set_chg", {31'd0, bus1.chg}, 32'h0);

    // JK mode: clear, then j=1010 k=0110 twice
    set = 1'b1;
    bus.en = 1'b1;
    bus.mode = MODE_JK;
    bus.j = 4'h0;
    bus.k = 4'hF;
    tick();
    check("jk_clr_q", {28'd0, bus.q}, 32'h0);
    bus.j = 4'b1010;
    bus.k = 4'b0110;
    tick();
    check("jk1_q", {28'd0, bus.q}, 32'hA);
    check("jk1_chg", {28'd0, bus.chg}, 32'hA);
    tick();
    check("jk2_q", {28'd0, bus.q}, 32'h8);
    check("jk2_chg", {28'd0, bus.chg}, 32'h2);
    check("jk2_qb", {28'd0, bus.qb}, 32'h7);

    // D mode, k driven to the opposite pattern to show it is ignored
    bus.mode = MODE_D;
    bus.j = 4'h0;
    bus.k = 4'hF;
    tick();
    check("d0_q", {28'd0, bus.q}, 32'h0);
    bus.j = 4'h5;
    bus.k = 4'h5;
    tick();
    check("d5_q", {28'd0, bus.q}, 32'h5);
    check("d5_chg", {28'd0, bus.chg}, 32'h5);
    bus.j = 4'hA;
    bus.k = 4'h0;
    tick();
    check("da_q", {28'd0, bus.q}, 32'hA);
    check("da_chg", {28'd0, bus.chg}, 32'hF);

    // T mode from q=3
    bus.j = 4'h3;
    tick();
    bus.mode = MODE_T;
    bus.j = 4'h6;
    bus.k = 4'h0;
    tick();
    check("t_q", {28'd0, bus.q}, 32'h5);
    check("t_chg", {28'd0, bus.chg}, 32'h6);
    bus.en = 1'b0;
    bus.j = 4'hF;
    tick();
    check("t_hold_q", {28'd0, bus.q}, 32'h5);
    check("t_hold_chg", {28'd0, bus.chg}, 32'h0);

    // COUNT mode from reset
    rst = 1'b0;
    tick();
    check("cnt_rst_q", {28'd0, bus.q}, 32'h0);
    check("cnt_rst_chg", {28'd0, bus.chg}, 32'h0);
    rst = 1'b1;
    bus.mode = MODE_CNT;
    bus.en = 1'b1;
    bus.j = 4'h0;
    bus.k = 4'h0;
    #1;
    check("w1_tc", {31'd0, bus1.tc}, 32'h1);
    cnt = 4'h0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("cnt_tc_%0d", i), {31'd0, bus.tc}, (cnt == 4'hF) ? 32'h1 : 32'h0);
      prev = cnt;
      tick();
      cnt = cnt + 4'h1;
      check($sformatf("cnt_q_%0d", i), {28'd0, bus.q}, {28'd0, cnt});
      check($sformatf("cnt_chg_%0d", i), {28'd0, bus.chg}, {28'd0, prev ^ cnt});
      if (i == 0) begin
        check("w1_cnt_q", {31'd0, bus1.q}, 32'h0);
      end
    end

    // Count to 7, then hold with en=0
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    check("cnt7_q", {28'd0, bus.q}, 32'h7);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_q_%0d", i), {28'd0, bus.q}, 32'h7);
      check($sformatf("hold_chg_%0d", i), {28'd0, bus.chg}, 32'h0);
      check($sformatf("hold_tc_%0d", i), {31'd0, bus.tc}, 32'h0);
    end

    // Run to F; tc follows en combinationally
    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    check("cntf_q", {28'd0, bus.q}, 32'hF);
    check("cntf_tc", {31'd0, bus.tc}, 32'h1);
    bus.en = 1'b0;
    #1;
    check("cntf_tc_en0", {31'd0, bus.tc}, 32'h0);
    bus.en = 1'b1;
    tick();
    check("wrap_q", {28'd0, bus.q}, 32'h0);
    check("wrap_chg", {28'd0, bus.chg}, 32'hF);

    // Mid-count reset at 9 with preset also low
    for (int i = 0; i < 9; i++) begin
      tick();
    end
    check("cnt9_q", {28'd0, bus.q}, 32'h9);
    rst = 1'b0;
    set = 1'b0;
    tick();
    check("mid_rst_q", {28'd0, bus.q}, 32'h0);
    check("mid_rst_chg", {28'd0, bus.chg}, 32'h0);

    // Reset still applies with en=0
    rst = 1'b1;
    set = 1'b1;
    tick();
    check("cnt1_q", {28'd0, bus.q}, 32'h1);
    bus.en = 1'b0;
    rst = 1'b0;
    tick();
    check("rst_en0_q", {28'd0, bus.q}, 32'h0);
    check("rst_en0_chg", {28'd0, bus.chg}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
